// File: rtl/demux1to4.sv
// 1-to-4 demultiplexer feeding four independent DEPTH-entry FIFOs.
// Words are steered to a FIFO by ctrl, and each FIFO shows its oldest word on out1..out4.
module demux1to4 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ctrl,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
);

    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem   [NCH][DEPTH];
    logic [PW-1:0]    rptr  [NCH];
    logic [PW-1:0]    wptr  [NCH];
    logic [CW-1:0]    count [NCH];
    logic [WIDTH-1:0] head  [NCH];
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;

    // Handshake decode. A full channel refuses the push even when a same-cycle pop is possible.
    always_comb begin
        in_ready  = rst_n && (count[ctrl] != CW'(DEPTH));
        push      = '0;
        pop       = '0;
        out_valid = '0;
        for (int k = 0; k < NCH; k++) begin
            out_valid[k] = (count[k] != '0);
            push[k]      = in_valid && in_ready && (ctrl == 2'(k));
            pop[k]       = out_valid[k] && out_ready[k];
            head[k]      = out_valid[k] ? mem[k][rptr[k]] : '0;
        end
    end

    assign out1 = head[0];
    assign out2 = head[1];
    assign out3 = head[2];
    assign out4 = head[3];

    // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                rptr[k]  <= '0;
                wptr[k]  <= '0;
                count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (push[k]) wptr[k] <= wptr[k] + PW'(1);
                if (pop[k])  rptr[k] <= rptr[k] + PW'(1);
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + CW'(1);
                    2'b01:   count[k] <= count[k] - CW'(1);
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    // Storage needs no reset; stale entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (push[k]) mem[k][wptr[k]] <= in_data;
        end
    end

endmodule

// File: tb/tb_demux1to4.sv
// Directed self-checking bench for demux1to4 (WIDTH=32, DEPTH=2).
module tb_demux1to4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1, out2, out3, out4;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int errors = 0;
    int checks = 0;

    demux1to4 #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (ctrl),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [1:0] c, input logic [31:0] d);
        in_valid = 1'b1;
        ctrl     = c;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] q[$];
    logic        exp_ready;
    logic        exp_pop;
    int          pushed;
    int          popped;

    initial begin
        rst_n = 1'b0; ctrl = 2'd0; in_data = '0; in_valid = 1'b0; out_ready = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out1", out1, 32'd0);
        rst_n = 1'b1;
        settle();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word to channel 2
        push_word(2'd2, 32'hAAAA_0001);
        check("ch2_valid", 32'(out_valid), 32'h4);
        check("ch2_out3", out3, 32'hAAAA_0001);
        check("ch2_out1", out1, 32'd0);
        check("ch2_out2", out2, 32'd0);
        check("ch2_out4", out4, 32'd0);
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        check("ch2_drain_valid", 32'(out_valid), 32'd0);
        check("ch2_drain_out3", out3, 32'd0);

        // Channel 0 fill, stall on the third word, then drain
        push_word(2'd0, 32'h11);
        push_word(2'd0, 32'h22);
        in_valid = 1'b1; ctrl = 2'd0; in_data = 32'h33;
        settle();
        check("ch0_full_ready", 32'(in_ready), 32'd0);
        tick();
        check("ch0_stall_out1", out1, 32'h11);
        check("ch0_stall_valid", 32'(out_valid), 32'h1);
        out_ready = 4'b0001;
        settle();
        check("ch0_full_pop_ready", 32'(in_ready), 32'd0);
        tick();
        check("ch0_second_out1", out1, 32'h22);
        check("ch0_room_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("ch0_pushpop_out1", out1, 32'h33);
        check("ch0_pushpop_valid", 32'(out_valid), 32'h1);
        tick();
        out_ready = 4'b0000;
        check("ch0_empty_valid", 32'(out_valid), 32'd0);
        check("ch0_empty_out1", out1, 32'd0);

        // Full channel 1 with simultaneous pop and push attempt
        push_word(2'd1, 32'h101);
        push_word(2'd1, 32'h102);
        in_valid = 1'b1; ctrl = 2'd1; in_data = 32'h103; out_ready = 4'b0010;
        settle();
        check("ch1_full_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        check("ch1_after_valid", 32'(out_valid), 32'h2);
        check("ch1_after_out2", out2, 32'h102);
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        check("ch1_drained", 32'(out_valid), 32'd0);

        // One word per channel, all popped together
        push_word(2'd0, 32'h10);
        push_word(2'd1, 32'h20);
        push_word(2'd2, 32'h30);
        push_word(2'd3, 32'h40);
        check("all_valid", 32'(out_valid), 32'hF);
        check("all_out1", out1, 32'h10);
        check("all_out2", out2, 32'h20);
        check("all_out3", out3, 32'h30);
        check("all_out4", out4, 32'h40);
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        check("all_popped", 32'(out_valid), 32'd0);

        // Channel 3 streaming with toggling out_ready; small queue model tracks contents
        pushed = 0;
        popped = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid  = (pushed < 10);
            ctrl      = 2'd3;
            in_data   = 32'h300 + 32'(pushed);
            out_ready = {i[0], 3'b000};
            settle();
            exp_ready = (q.size() < 2);
            exp_pop   = (q.size() > 0) && i[0];
            check($sformatf("ch3_ready_%0d", i), 32'(in_ready), 32'(exp_ready));
            if (q.size() > 0) check($sformatf("ch3_head_%0d", i), out4, q[0]);
            tick();
            if (exp_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (in_valid && exp_ready) begin
                q.push_back(in_data);
                pushed++;
            end
        end
        in_valid = 1'b0; out_ready = 4'b0000;
        check("ch3_popped_count", 32'(popped), 32'd10);
        check("ch3_final_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of traffic
        push_word(2'd0, 32'hA0);
        push_word(2'd0, 32'hA1);
        push_word(2'd2, 32'hC0);
        push_word(2'd2, 32'hC1);
        check("prerst_valid", 32'(out_valid), 32'h5);
        rst_n = 1'b0; in_valid = 1'b1; ctrl = 2'd1; in_data = 32'h77;
        settle();
        check("midrst_ready", 32'(in_ready), 32'd0);
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_out1", out1, 32'd0);
        check("midrst_out3", out3, 32'd0);
        check("midrst_ready_held", 32'(in_ready), 32'd0);
        rst_n = 1'b1; in_data = 32'h55;
        settle();
        check("postrst_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("postrst_valid", 32'(out_valid), 32'h2);
        check("postrst_out2", out2, 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
